// File: rtl/apbdma_downsizer.sv
// Wide-to-narrow stream width converter on the DMA write path; emits each buffered word LSB slice first.
// Optional macro APBDMA_DOWNSIZER_SKIP_EMPTY_EN: skip slices whose strobes are all zero.
module apbdma_downsizer #(
  parameter int InDataWidth  = 64,
  parameter int OutDataWidth = 32
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic [InDataWidth-1:0]    data_i,
  input  logic [InDataWidth/8-1:0]  strb_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  output logic [OutDataWidth-1:0]   data_o,
  output logic [OutDataWidth/8-1:0] strb_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      last_o
);

  localparam int Ratio      = InDataWidth / OutDataWidth;
  localparam int CntW       = $clog2(Ratio);
  localparam int SliceStrbW = OutDataWidth / 8;

  typedef enum logic {
    Idle,
    Send
  } state_t;

  state_t                   state_q;
  logic [InDataWidth-1:0]   data_q;
  logic [InDataWidth/8-1:0] strb_q;
  logic [CntW-1:0]          count_q;

  logic [CntW-1:0] first_idx;
  logic [CntW-1:0] next_idx;
  logic            in_any;
  logic            has_next;

  // first_idx/in_any describe an incoming word; next_idx/has_next the buffered one.
  always_comb begin
    first_idx = '0;
    next_idx  = '0;
    in_any    = 1'b0;
    has_next  = 1'b0;
`ifdef APBDMA_DOWNSIZER_SKIP_EMPTY_EN
    for (int i = Ratio - 1; i >= 0; i--) begin
      if (|strb_i[i*SliceStrbW +: SliceStrbW]) begin
        first_idx = CntW'(i);
        in_any    = 1'b1;
      end
      if ((|strb_q[i*SliceStrbW +: SliceStrbW]) && (CntW'(i) > count_q)) begin
        next_idx = CntW'(i);
        has_next = 1'b1;
      end
    end
`else
    in_any   = 1'b1;
    has_next = (count_q != CntW'(Ratio - 1));
    next_idx = count_q + CntW'(1);
`endif
  end

  assign valid_o = (state_q == Send);
  assign last_o  = (state_q == Send) && !has_next;
  assign ready_o = (state_q == Idle) || (ready_i && last_o);
  assign data_o  = data_q[count_q*OutDataWidth +: OutDataWidth];
  assign strb_o  = strb_q[count_q*SliceStrbW +: SliceStrbW];

  // A word with no live slices is consumed by the handshake but never buffered.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= Idle;
      data_q  <= '0;
      strb_q  <= '0;
      count_q <= '0;
    end else begin
      case (state_q)
        Idle: begin
          if (valid_i && in_any) begin
            data_q  <= data_i;
            strb_q  <= strb_i;
            count_q <= first_idx;
            state_q <= Send;
          end
        end
        Send: begin
          if (ready_i) begin
            if (!last_o) begin
              count_q <= next_idx;
            end else if (valid_i && in_any) begin
              data_q  <= data_i;
              strb_q  <= strb_i;
              count_q <= first_idx;
            end else begin
              count_q <= '0;
              state_q <= Idle;
            end
          end
        end
        default: begin
          state_q <= Idle;
          count_q <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apbdma_downsizer.sv
// Directed self-checking bench for apbdma_downsizer at In=64 / Out=32.
module tb_apbdma_downsizer;

  logic        clk_i;
  logic        rst_i;
  logic [63:0] data_i;
  logic [7:0]  strb_i;
  logic        valid_i;
  logic        ready_o;
  logic [31:0] data_o;
  logic [3:0]  strb_o;
  logic        valid_o;
  logic        ready_i;
  logic        last_o;

  int checks;
  int failures;

  apbdma_downsizer #(
    .InDataWidth (64),
    .OutDataWidth(32)
  ) dut (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .data_i (data_i),
    .strb_i (strb_i),
    .valid_i(valid_i),
    .ready_o(ready_o),
    .data_o (data_o),
    .strb_o (strb_o),
    .valid_o(valid_o),
    .ready_i(ready_i),
    .last_o (last_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [63:0] d, input logic [7:0] s, input logic v, input logic r);
    data_i  = d;
    strb_i  = s;
    valid_i = v;
    ready_i = r;
    #1;
  endtask

  // Advance one clock; inputs change and outputs are sampled 1ns after the rising edge.
  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic checkSlice(input string tag, input logic [31:0] d, input logic [3:0] s,
                            input logic lst, input logic rdy);
    checkOutput({tag, ".valid"}, {63'd0, valid_o}, 64'd1);
    checkOutput({tag, ".data"},  {32'd0, data_o},  {32'd0, d});
    checkOutput({tag, ".strb"},  {60'd0, strb_o},  {60'd0, s});
    checkOutput({tag, ".last"},  {63'd0, last_o},  {63'd0, lst});
    checkOutput({tag, ".ready"}, {63'd0, ready_o}, {63'd0, rdy});
  endtask

  task automatic checkIdle(input string tag);
    checkOutput({tag, ".valid"}, {63'd0, valid_o}, 64'd0);
    checkOutput({tag, ".ready"}, {63'd0, ready_o}, 64'd1);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_i    = 1'b1;
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b0);

    checkIdle("reset");
    checkOutput("reset.last", {63'd0, last_o}, 64'd0);
    checkOutput("reset.data", {32'd0, data_o}, 64'd0);
    checkOutput("reset.strb", {60'd0, strb_o}, 64'd0);
    tick();
    rst_i = 1'b0;
    tick();

    // Single word
    applyStimulus(64'h1122334455667788, 8'hFF, 1'b1, 1'b1);
    checkOutput("t1.accept_ready", {63'd0, ready_o}, 64'd1);
    tick();
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b1);
    checkSlice("t1.s0", 32'h55667788, 4'hF, 1'b0, 1'b0);
    tick();
    checkSlice("t1.s1", 32'h11223344, 4'hF, 1'b1, 1'b1);
    tick();
    checkIdle("t1.idle");

    // Back-to-back words with no bubble
    applyStimulus(64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b1);
    tick();
    applyStimulus(64'hFEDCBA9876543210, 8'hFF, 1'b1, 1'b1);
    checkSlice("t2.a0", 32'h89ABCDEF, 4'hF, 1'b0, 1'b0);
    tick();
    checkSlice("t2.a1", 32'h01234567, 4'hF, 1'b1, 1'b1);
    tick();
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b1);
    checkSlice("t2.b0", 32'h76543210, 4'hF, 1'b0, 1'b0);
    tick();
    checkSlice("t2.b1", 32'hFEDCBA98, 4'hF, 1'b1, 1'b1);
    tick();
    checkIdle("t2.idle");

    // Backpressure on slice 0
    applyStimulus(64'h1122334455667788, 8'hFF, 1'b1, 1'b1);
    tick();
    applyStimulus(64'hDEADBEEFCAFEF00D, 8'hFF, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkSlice($sformatf("t3.hold%0d", i), 32'h55667788, 4'hF, 1'b0, 1'b0);
      tick();
    end
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b1);
    checkSlice("t3.release", 32'h55667788, 4'hF, 1'b0, 1'b0);
    tick();
    checkSlice("t3.s1", 32'h11223344, 4'hF, 1'b1, 1'b1);
    tick();
    checkIdle("t3.idle");

    // Reset after slice 0 handshakes
    applyStimulus(64'h1122334455667788, 8'hFF, 1'b1, 1'b1);
    tick();
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b1);
    tick();
    checkSlice("t4.s1_pending", 32'h11223344, 4'hF, 1'b1, 1'b1);
    rst_i = 1'b1;
    #1;
    checkOutput("t4.valid_async", {63'd0, valid_o}, 64'd0);
    tick();
    rst_i = 1'b0;
    tick();
    checkIdle("t4.after");
    checkOutput("t4.data", {32'd0, data_o}, 64'd0);
    tick();
    checkOutput("t4.no_s1", {63'd0, valid_o}, 64'd0);

    // Partial strobe on the upper slice only
    applyStimulus(64'h1122334455667788, 8'hF0, 1'b1, 1'b1);
    tick();
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b1);
`ifdef APBDMA_DOWNSIZER_SKIP_EMPTY_EN
    checkSlice("t5.only", 32'h11223344, 4'hF, 1'b1, 1'b1);
`else
    checkSlice("t5.s0", 32'h55667788, 4'h0, 1'b0, 1'b0);
    tick();
    checkSlice("t5.s1", 32'h11223344, 4'hF, 1'b1, 1'b1);
`endif
    tick();
    checkIdle("t5.idle");

`ifdef APBDMA_DOWNSIZER_SKIP_EMPTY_EN
    // All-zero strobe word is swallowed, the following full word is sent normally
    applyStimulus(64'hAAAAAAAABBBBBBBB, 8'h00, 1'b1, 1'b1);
    checkOutput("t6.drop_ready", {63'd0, ready_o}, 64'd1);
    tick();
    checkIdle("t6.dropped");
    applyStimulus(64'h0123456789ABCDEF, 8'hFF, 1'b1, 1'b1);
    tick();
    applyStimulus(64'd0, 8'd0, 1'b0, 1'b1);
    checkSlice("t6.s0", 32'h89ABCDEF, 4'hF, 1'b0, 1'b0);
    tick();
    checkSlice("t6.s1", 32'h01234567, 4'hF, 1'b1, 1'b1);
    tick();
    checkIdle("t6.idle");
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/apbdma_downsizer.md
Name: apbdma_downsizer

Overview:
- Width converter from a wide data/strobe stream to a narrow one: each accepted InDataWidth word is split into InDataWidth/OutDataWidth slices, emitted least-significant slice first.
- Sits on the DMA write path, between the wide internal datapath and the narrow APB-side consumer.
- Complements the upsizer on the read path.
- Valid/ready handshake on both sides; one word buffered.

Parameters:
- InDataWidth, 64, input data width in bits; multiple of 8 and of OutDataWidth.
- OutDataWidth, 32, output data width in bits; multiple of 8.
- Derived: Ratio = InDataWidth/OutDataWidth, power of two, at least 2. CntW = $clog2(Ratio).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  asynchronous reset, active-high.
- data_i  in  InDataWidth  wide input data.
- strb_i  in  InDataWidth/8  byte strobes for data_i.
- valid_i  in  1  input word valid.
- ready_o  out  1  input word accepted when valid_i && ready_o.
- data_o  out  OutDataWidth  current slice of the buffered word.
- strb_o  out  OutDataWidth/8  strobes of the current slice.
- valid_o  out  1  slice valid.
- ready_i  in  1  slice consumed when valid_o && ready_i.
- last_o  out  1  current slice is the final one emitted for the buffered word.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is asynchronous and active-high (rst_i).
  - Reset values: state=Idle, count=0, buffered data=0, buffered strb=0.
  - While in Idle after reset, outputs are valid_o=0, last_o=0, data_o=0, strb_o=0, ready_o=1.
- Registers: data_q (InDataWidth), strb_q (InDataWidth/8), count_q (CntW), state_q.
- Output slicing:
  - data_o = data_q[count_q*OutDataWidth +: OutDataWidth].
  - strb_o = strb_q[count_q*OutDataWidth/8 +: OutDataWidth/8].
- State Idle:
  - ready_o=1, valid_o=0.
  - On valid_i: capture data_i and strb_i, set count_q=0, go to Send.
  - Latency: first slice is valid on the cycle after acceptance.
- State Send:
  - valid_o=1.
  - last_o=1 iff count_q==Ratio-1.
  - ready_o = ready_i && last_o. This is a combinational path from ready_i to ready_o.
- Send transitions:
  - ready_i=0: hold data_q, strb_q and count_q. data_o and strb_o stay stable.
  - ready_i=1, not last: count_q increments by 1.
  - ready_i=1, last, valid_i=1: capture the new word, set count_q=0, stay in Send. No bubble between words.
  - ready_i=1, last, valid_i=0: go to Idle, count_q=0.
- Throughput: one slice per cycle under continuous ready_i, so one word per Ratio cycles.
- count_q never wraps past Ratio-1. Reset to 0 is explicit on every word acceptance.
- Reset mid-word: the current word is discarded, valid_o drops asynchronously, and no remaining slices are emitted.
- Input values are ignored while ready_o=0; valid_i may stay asserted.

Optional Feature:
- Macro: APBDMA_DOWNSIZER_SKIP_EMPTY_EN.
- Defined:
  - Slices whose strobe bits are all zero are never emitted.
  - On acceptance, count_q is set to the lowest slice index with a nonzero strobe.
  - After each handshake, count_q advances to the next nonzero-strobe slice.
  - last_o=1 on the highest nonzero-strobe slice.
  - A word with strb_i all zero is consumed (ready_o=1) and dropped: state stays Idle, or goes to Idle after the current word, and valid_o is never asserted for it.
- Undefined:
  - All Ratio slices are emitted, including zero-strobe ones.
  - last_o=1 only at count_q==Ratio-1.

Test Plan (In=64, Out=32):
1. Single word: accept data_i=0x1122334455667788, strb_i=0xFF, ready_i=1.
   - Cycle+1: data_o=0x55667788, strb_o=0xF, last_o=0, ready_o=0.
   - Cycle+2: data_o=0x11223344, strb_o=0xF, last_o=1, ready_o=1.
   - Then Idle with valid_o=0.
2. Back-to-back: valid_i held high with words A then B, ready_i=1.
   - Four consecutive slices A0, A1, B0, B1 with no gap.
   - B is accepted in the same cycle A1 handshakes.
3. Backpressure: ready_i=0 for 3 cycles during slice 0.
   - valid_o=1 throughout; data_o=0x55667788 and strb_o stable; count_q unchanged.
   - Slice 1 appears on the cycle after ready_i returns to 1.
4. Reset mid-word: rst_i=1 after slice 0 handshakes.
   - valid_o=0 immediately.
   - After release: ready_o=1, data_o=0, and slice 1 is never emitted.
5. Partial strobe, strb_i=0xF0:
   - Without macro: two beats, strb_o=0x0 then 0xF.
   - With APBDMA_DOWNSIZER_SKIP_EMPTY_EN: one beat, data_o=0x11223344, strb_o=0xF, last_o=1.
6. With macro, strb_i=0x00 followed by a full word:
   - First word is consumed in one cycle with no valid_o.
   - Second word is emitted normally as two beats.
